// File: rtl/peripheral_operand_sequencer_if.sv
// Front-panel bus between the board keys/switches and the operand sequencer.
// The master side drives keys, switches and the datapath result; the slave side is the sequencer.
interface peripheral_operand_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int N_OPS  = 2
);
  logic                      enter;
  logic                      clear;
  logic [BYTE_W-1:0]         inputdata;
  logic [DATA_W-1:0]         dataR;
  logic [N_OPS*DATA_W-1:0]   operands;
  logic                      inputdata_ready;
  logic                      load_done;
  logic [3:0]                disp_name;
  logic [3:0]                disp_index;
  logic [7:0]                disp_byte;

  modport master (
    output enter, clear, inputdata, dataR,
    input  operands, inputdata_ready, load_done, disp_name, disp_index, disp_byte
  );

  modport slave (
    input  enter, clear, inputdata, dataR,
    output operands, inputdata_ready, load_done, disp_name, disp_index, disp_byte
  );
endinterface

// File: rtl/peripheral_operand_sequencer.sv
// Loads N_OPS operands one byte per debounced 'enter' press, then steps through the
// result bytes; drives the name/index/byte nibbles shown on the 7-segment displays.
module peripheral_operand_sequencer #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int N_OPS  = 2
) (
  input logic clk,
  input logic reset,
  peripheral_operand_sequencer_if.slave bus
);
  localparam int BYTES = DATA_W / BYTE_W;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int OP_W  = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(BYTES - 1);
  localparam logic [OP_W-1:0]  LAST_OP   = OP_W'(N_OPS - 1);

  generate
    if (DATA_W % BYTE_W != 0) begin : g_bad_width
      $error("DATA_W must be an integer multiple of BYTE_W");
    end
    if (N_OPS < 1 || N_OPS > 5) begin : g_bad_nops
      $error("N_OPS must be in 1..5");
    end
  endgenerate

  typedef enum logic {LOAD, SHOW} state_t;

  state_t                  state_q, state_d;
  logic [OP_W-1:0]         op_idx_q, op_idx_d;
  logic [IDX_W-1:0]        byte_idx_q, byte_idx_d;
  logic [N_OPS*DATA_W-1:0] operands_q, operands_d;
  logic                    load_done_q, load_done_d;
  logic                    enter_s1_q, enter_s2_q, enter_s3_q;
  logic                    press_p0;
  logic                    press_p1_q;

  // Stage p0: rising edge of the synchronised key level
  assign press_p0 = enter_s2_q & ~enter_s3_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enter_s1_q  <= 1'b0;
      enter_s2_q  <= 1'b0;
      enter_s3_q  <= 1'b0;
      press_p1_q  <= 1'b0;
      state_q     <= LOAD;
      op_idx_q    <= '0;
      byte_idx_q  <= '0;
      operands_q  <= '0;
      load_done_q <= 1'b0;
    end else begin
      enter_s1_q  <= bus.enter;
      enter_s2_q  <= enter_s1_q;
      enter_s3_q  <= enter_s2_q;
      press_p1_q  <= press_p0;
      state_q     <= state_d;
      op_idx_q    <= op_idx_d;
      byte_idx_q  <= byte_idx_d;
      operands_q  <= operands_d;
      load_done_q <= load_done_d;
    end
  end

  // Stage p1: registered press acts on the sequencer state
  always_comb begin
    state_d     = state_q;
    op_idx_d    = op_idx_q;
    byte_idx_d  = byte_idx_q;
    operands_d  = operands_q;
    load_done_d = 1'b0;
    if (bus.clear) begin
      state_d    = LOAD;
      op_idx_d   = '0;
      byte_idx_d = '0;
      operands_d = '0;
    end else if (press_p1_q) begin
      if (state_q == LOAD) begin
        for (int k = 0; k < N_OPS; k++) begin
          for (int b = 0; b < BYTES; b++) begin
            if (op_idx_q == OP_W'(k) && byte_idx_q == IDX_W'(b)) begin
              operands_d[k*DATA_W + b*BYTE_W +: BYTE_W] = bus.inputdata;
            end
          end
        end
        if (byte_idx_q == LAST_BYTE) begin
          byte_idx_d = '0;
          if (op_idx_q == LAST_OP) begin
            state_d     = SHOW;
            load_done_d = 1'b1;
          end else begin
            op_idx_d = op_idx_q + OP_W'(1);
          end
        end else begin
          byte_idx_d = byte_idx_q + IDX_W'(1);
        end
      end else begin
        if (byte_idx_q == LAST_BYTE) begin
          state_d    = LOAD;
          op_idx_d   = '0;
          byte_idx_d = '0;
        end else begin
          byte_idx_d = byte_idx_q + IDX_W'(1);
        end
      end
    end
  end

  // Display nibbles follow the registered state with no added latency
  always_comb begin
    bus.disp_byte = 8'(bus.inputdata);
    if (state_q == SHOW) begin
      bus.disp_name = 4'hA + 4'(N_OPS);
      for (int b = 0; b < BYTES; b++) begin
        if (byte_idx_q == IDX_W'(b)) begin
          bus.disp_byte = 8'(bus.dataR[b*BYTE_W +: BYTE_W]);
        end
      end
    end else begin
      bus.disp_name = 4'hA + 4'(op_idx_q);
    end
  end

  assign bus.disp_index      = 4'(byte_idx_q);
  assign bus.operands        = operands_q;
  assign bus.inputdata_ready = (state_q == SHOW);
  assign bus.load_done       = load_done_q;
endmodule

// File: tb/tb_peripheral_operand_sequencer.sv
// Bench for peripheral_operand_sequencer: two instances (32-bit x2 and 16-bit x3) driven
// press by press, with a reference model feeding a cycle-stamped scoreboard.
module tb_peripheral_operand_sequencer;
  localparam int BW  = 8;
  localparam int DW0 = 32;
  localparam int N0  = 2;
  localparam int DW1 = 16;
  localparam int N1  = 3;

  logic clk;
  logic rst0, rst1;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  peripheral_operand_sequencer_if #(.DATA_W(DW0), .BYTE_W(BW), .N_OPS(N0)) if0 ();
  peripheral_operand_sequencer_if #(.DATA_W(DW1), .BYTE_W(BW), .N_OPS(N1)) if1 ();

  peripheral_operand_sequencer #(.DATA_W(DW0), .BYTE_W(BW), .N_OPS(N0)) dut0 (
    .clk(clk), .reset(rst0), .bus(if0));
  peripheral_operand_sequencer #(.DATA_W(DW1), .BYTE_W(BW), .N_OPS(N1)) dut1 (
    .clk(clk), .reset(rst1), .bus(if1));

  typedef struct {
    int          dut;
    int          due;
    logic [95:0] ops;
    logic [3:0]  name;
    logic [3:0]  idx;
    logic        rdy;
    logic        done;
    logic [7:0]  byt;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [95:0] m_ops [2];
  int          m_op  [2];
  int          m_byte[2];
  bit          m_show[2];

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int dw_of(input int d);
    return (d == 0) ? DW0 : DW1;
  endfunction

  function automatic int nops_of(input int d);
    return (d == 0) ? N0 : N1;
  endfunction

  function automatic exp_t snap(input int d, input int due, input bit done);
    exp_t e;
    e.dut  = d;
    e.due  = due;
    e.ops  = m_ops[d];
    e.name = m_show[d] ? 4'hA + 4'(nops_of(d)) : 4'hA + 4'(m_op[d]);
    e.idx  = 4'(m_byte[d]);
    e.rdy  = m_show[d];
    e.done = done;
    if (m_show[d]) e.byt = (d == 0) ? if0.dataR[m_byte[d]*BW +: 8] : if1.dataR[m_byte[d]*BW +: 8];
    else           e.byt = (d == 0) ? if0.inputdata : if1.inputdata;
    return e;
  endfunction

  task automatic model_reset(input int d);
    m_ops[d]  = '0;
    m_op[d]   = 0;
    m_byte[d] = 0;
    m_show[d] = 0;
  endtask

  task automatic compare(input exp_t e);
    string p;
    p = $sformatf("d%0d_c%0d_", e.dut, e.due);
    if (e.dut == 0) begin
      chk({p, "operands"}, 96'(if0.operands), e.ops);
      chk({p, "disp_name"}, 96'(if0.disp_name), 96'(e.name));
      chk({p, "disp_index"}, 96'(if0.disp_index), 96'(e.idx));
      chk({p, "ready"}, 96'(if0.inputdata_ready), 96'(e.rdy));
      chk({p, "load_done"}, 96'(if0.load_done), 96'(e.done));
      chk({p, "disp_byte"}, 96'(if0.disp_byte), 96'(e.byt));
    end else begin
      chk({p, "operands"}, 96'(if1.operands), e.ops);
      chk({p, "disp_name"}, 96'(if1.disp_name), 96'(e.name));
      chk({p, "disp_index"}, 96'(if1.disp_index), 96'(e.idx));
      chk({p, "ready"}, 96'(if1.inputdata_ready), 96'(e.rdy));
      chk({p, "load_done"}, 96'(if1.load_done), 96'(e.done));
      chk({p, "disp_byte"}, 96'(if1.disp_byte), 96'(e.byt));
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() != 0 && sbq[0].due == cyc) begin
      compare(sbq.pop_front());
    end
  end

  // One key press on instance d; optionally with clear landing on the same edge as the press.
  task automatic press(input int d, input logic [7:0] data, input int hold, input bit clr_with);
    int n;
    bit done;
    @(negedge clk);
    if (d == 0) begin if0.inputdata = data; if0.enter = 1'b1; end
    else        begin if1.inputdata = data; if1.enter = 1'b1; end
    n = cyc;
    sbq.push_back(snap(d, n + 3, 1'b0));
    done = 1'b0;
    if (clr_with) begin
      model_reset(d);
    end else if (!m_show[d]) begin
      m_ops[d][m_op[d]*dw_of(d) + m_byte[d]*BW +: 8] = data;
      if (m_byte[d] == dw_of(d)/BW - 1) begin
        m_byte[d] = 0;
        if (m_op[d] == nops_of(d) - 1) begin
          m_show[d] = 1;
          done = 1'b1;
        end else begin
          m_op[d]++;
        end
      end else begin
        m_byte[d]++;
      end
    end else begin
      if (m_byte[d] == dw_of(d)/BW - 1) begin
        m_show[d] = 0;
        m_op[d]   = 0;
        m_byte[d] = 0;
      end else begin
        m_byte[d]++;
      end
    end
    sbq.push_back(snap(d, n + 4, done));
    sbq.push_back(snap(d, n + 5, 1'b0));
    for (int i = 1; i <= hold + 6; i++) begin
      @(negedge clk);
      if (d == 0) begin if0.clear = clr_with && (i == 3); if0.enter = (i < hold); end
      else        begin if1.clear = clr_with && (i == 3); if1.enter = (i < hold); end
    end
    if (sbq.size() != 0) begin
      chk("scoreboard_drain", 96'(sbq.size()), 96'(0));
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [7:0] seq0 [8];
    seq0 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    rst0 = 1'b1; rst1 = 1'b1;
    if0.enter = 1'b0; if0.clear = 1'b0; if0.inputdata = '0; if0.dataR = '0;
    if1.enter = 1'b0; if1.clear = 1'b0; if1.inputdata = '0; if1.dataR = '0;
    model_reset(0);
    model_reset(1);
    repeat (3) @(negedge clk);
    compare(snap(0, cyc, 1'b0));
    compare(snap(1, cyc, 1'b0));
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (2) @(negedge clk);

    // Full load of A and B with varying hold lengths
    for (int i = 0; i < 8; i++) press(0, seq0[i], (i % 3) + 1, 1'b0);
    chk("A_value", 96'(if0.operands[31:0]), 96'(32'h44332211));
    chk("B_value", 96'(if0.operands[63:32]), 96'(32'h88776655));

    // Step through result bytes; the last press wraps back to LOAD
    if0.dataR = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) press(0, 8'h00, 1, 1'b0);

    // Long hold writes exactly one slice
    press(0, 8'h5A, 20, 1'b0);

    // Three more bytes of A, three of B, then clear on the same edge as a press
    for (int i = 0; i < 6; i++) press(0, 8'(8'hA0 + i), 2, 1'b0);
    press(0, 8'hEE, 2, 1'b1);
    press(0, 8'h3C, 1, 1'b0);

    // 16-bit x3 instance: fill A,B,C then show result bytes
    if1.dataR = 16'hCAFE;
    for (int i = 0; i < 6; i++) press(1, 8'(8'h10 + i), 1, 1'b0);
    for (int i = 0; i < 2; i++) press(1, 8'h00, 1, 1'b0);

    // Reset mid-round discards partial loads
    for (int i = 0; i < 4; i++) press(1, 8'(8'hC0 + i), 1, 1'b0);
    @(negedge clk);
    #2 rst1 = 1'b1;
    #1;
    model_reset(1);
    compare(snap(1, cyc, 1'b0));
    @(negedge clk);
    rst1 = 1'b0;
    repeat (2) @(negedge clk);
    press(1, 8'h99, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
